// File: rtl/legv8_fetch_unit.sv
// LEGv8 fetch unit: owns the PC, fetches one 32-bit word per req/ack handshake, hands it to control.
// Latency: one IDLE cycle after reset, then at least 1 cycle req->valid; 2 cycles/instr with zero-wait memory.
// Backpressure: holds the instruction (instr_valid=1) until instr_advance; holds mem_req until mem_ack.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned next-PC -> sticky FAULT instead of forcing [1:0]=0).
module legv8_fetch_unit #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [63:0] pc,
  input  logic        instr_advance,
  input  logic [1:0]  pc_sel,
  input  logic [63:0] branch_offset,
  input  logic [63:0] branch_reg,
  output logic [63:0] mem_addr,
  output logic        mem_req,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        fault
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      r_state;
  logic [63:0] r_pc;
  logic [31:0] r_instr;
  logic        r_instr_valid;
  logic        r_mem_req;
  logic [63:0] w_next_pc_raw;
  logic [63:0] w_next_pc;

  // Next-PC candidate from the control unit's select fields (64-bit wrap-around arithmetic)
  always_comb begin
    w_next_pc_raw = r_pc + 64'd4;
    case (pc_sel)
      2'b00:   w_next_pc_raw = r_pc + 64'd4;
      2'b01:   w_next_pc_raw = r_pc + branch_offset;
      2'b10:   w_next_pc_raw = branch_reg;
      default: w_next_pc_raw = r_pc;
    endcase
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;
  logic w_misaligned;

  // Misaligned targets are trapped rather than silently corrected
  always_comb begin
    w_next_pc    = w_next_pc_raw;
    w_misaligned = |w_next_pc_raw[1:0];
  end

  assign fault = r_fault;
`else
  // Without the check, low address bits are simply dropped so fetches stay word-aligned
  always_comb begin
    w_next_pc = {w_next_pc_raw[63:2], 2'b00};
  end

  assign fault = 1'b0;
`endif

  // Fetch FSM: all outputs are registered alongside the state
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= PC_RESET;
      r_instr       <= 32'h0;
      r_instr_valid <= 1'b0;
      r_mem_req     <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      r_fault       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state   <= S_REQ;
          r_mem_req <= 1'b1;
        end
        S_REQ: begin
          // Previous word stays visible until the new one arrives
          if (mem_ack) begin
            r_instr       <= mem_rdata;
            r_instr_valid <= 1'b1;
            r_mem_req     <= 1'b0;
            r_state       <= S_VALID;
          end
        end
        S_VALID: begin
          if (instr_advance) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_misaligned) begin
              r_instr_valid <= 1'b0;
              r_fault       <= 1'b1;
              r_state       <= S_FAULT;
            end else begin
              r_pc          <= w_next_pc;
              r_instr_valid <= 1'b0;
              r_mem_req     <= 1'b1;
              r_state       <= S_REQ;
            end
`else
            r_pc          <= w_next_pc;
            r_instr_valid <= 1'b0;
            r_mem_req     <= 1'b1;
            r_state       <= S_REQ;
`endif
          end
        end
        S_FAULT: begin
          // Sticky until reset; nothing is fetched or presented
          r_instr_valid <= 1'b0;
          r_mem_req     <= 1'b0;
        end
        default: begin
          r_state       <= S_IDLE;
          r_instr_valid <= 1'b0;
          r_mem_req     <= 1'b0;
        end
      endcase
    end
  end

  assign instruction = r_instr;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign mem_addr    = r_pc;
  assign mem_req     = r_mem_req;

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Directed bench for legv8_fetch_unit: table of PC-select vectors plus hand sequences
// for reset values, wait states, reset mid-fetch and the alignment corner.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_legv8_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic        instr_advance;
  logic [1:0]  pc_sel;
  logic [63:0] branch_offset;
  logic [63:0] branch_reg;
  logic [63:0] mem_addr;
  logic        mem_req;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        fault;

  int n_pass  = 0;
  int n_total = 0;

  legv8_fetch_unit #(.PC_RESET(64'h0)) dut (
    .clock         (clock),
    .reset         (reset),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .instr_advance (instr_advance),
    .pc_sel        (pc_sel),
    .branch_offset (branch_offset),
    .branch_reg    (branch_reg),
    .mem_addr      (mem_addr),
    .mem_req       (mem_req),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  sel;
    logic [63:0] off;
    logic [63:0] breg;
    int          wait_cyc;
    logic [31:0] word;
    logic [63:0] exp_addr;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [31:0] prev_word;

    // Expected addresses chain from one vector to the next, starting at pc=0
    vecs[0] = '{2'b00, 64'h0,                   64'h0,                   0, 32'hA000_0001, 64'h4};
    vecs[1] = '{2'b01, 64'h3C,                  64'h0,                   1, 32'hA000_0002, 64'h40};
    vecs[2] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFF0, 64'h0,                   0, 32'hA000_0003, 64'h30};
    vecs[3] = '{2'b10, 64'h0,                   64'h40,                  3, 32'hA000_0004, 64'h40};
    vecs[4] = '{2'b10, 64'h0,                   64'h1000,                0, 32'hA000_0005, 64'h1000};
    vecs[5] = '{2'b10, 64'h0,                   64'h40,                  0, 32'hA000_0006, 64'h40};
    vecs[6] = '{2'b11, 64'h1234,                64'h5678,                2, 32'hA000_0007, 64'h40};
    vecs[7] = '{2'b10, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFC, 0, 32'hA000_0008, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[8] = '{2'b00, 64'h0,                   64'h0,                   0, 32'hA000_0009, 64'h0};
    vecs[9] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,                   1, 32'hA000_000A, 64'hFFFF_FFFF_FFFF_FFF8};

    reset = 1'b1; instr_advance = 1'b0; pc_sel = 2'b00;
    branch_offset = 64'h0; branch_reg = 64'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_pc", pc, 64'h0);
    chk("rst_instr", {32'h0, instruction}, 64'h0);
    chk("rst_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_req", {63'h0, mem_req}, 64'h0);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_fault", {63'h0, fault}, 64'h0);

    // Leave reset: one IDLE cycle, then REQ; memory answers immediately
    reset = 1'b0;
    tick();
    chk("first_req", {63'h0, mem_req}, 64'h1);
    chk("first_addr", mem_addr, 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'h8B1F_0000;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    chk("first_valid", {63'h0, instr_valid}, 64'h1);
    chk("first_instr", {32'h0, instruction}, {32'h0, 32'h8B1F_0000});
    chk("first_pc", pc, 64'h0);
    chk("first_req_drop", {63'h0, mem_req}, 64'h0);
    prev_word = 32'h8B1F_0000;

    // Table-driven PC-select vectors
    for (int i = 0; i < 10; i++) begin
      instr_advance = 1'b1;
      pc_sel = vecs[i].sel; branch_offset = vecs[i].off; branch_reg = vecs[i].breg;
      tick();
      instr_advance = 1'b0; pc_sel = 2'b01; branch_offset = 64'h7777; branch_reg = 64'h9999;
      chk($sformatf("v%0d_addr", i), mem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_addr);
      chk($sformatf("v%0d_req", i), {63'h0, mem_req}, 64'h1);
      chk($sformatf("v%0d_valid_lo", i), {63'h0, instr_valid}, 64'h0);
      chk($sformatf("v%0d_instr_kept", i), {32'h0, instruction}, {32'h0, prev_word});

      // Wait states: advance pulses during REQ must be ignored
      for (int w = 0; w < vecs[i].wait_cyc; w++) begin
        instr_advance = 1'b1; pc_sel = 2'b10; branch_reg = 64'hDEAD_0000;
        tick();
        instr_advance = 1'b0;
        chk($sformatf("v%0d_w%0d_req", i, w), {63'h0, mem_req}, 64'h1);
        chk($sformatf("v%0d_w%0d_addr", i, w), mem_addr, vecs[i].exp_addr);
        chk($sformatf("v%0d_w%0d_valid", i, w), {63'h0, instr_valid}, 64'h0);
      end

      mem_ack = 1'b1; mem_rdata = vecs[i].word;
      tick();
      mem_ack = 1'b0; mem_rdata = 32'h0BAD_0BAD;
      chk($sformatf("v%0d_valid", i), {63'h0, instr_valid}, 64'h1);
      chk($sformatf("v%0d_instr", i), {32'h0, instruction}, {32'h0, vecs[i].word});
      chk($sformatf("v%0d_req_lo", i), {63'h0, mem_req}, 64'h0);

      // Hold in VALID with a stray ack: nothing may change
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk($sformatf("v%0d_hold_instr", i), {32'h0, instruction}, {32'h0, vecs[i].word});
      chk($sformatf("v%0d_hold_pc", i), pc, vecs[i].exp_addr);
      chk($sformatf("v%0d_hold_valid", i), {63'h0, instr_valid}, 64'h1);
      prev_word = vecs[i].word;
    end

    // Reset while waiting for an ack (pc currently 0xFFFF_FFFF_FFFF_FFF8)
    instr_advance = 1'b1; pc_sel = 2'b00;
    tick();
    instr_advance = 1'b0;
    chk("mid_req", mem_addr, 64'h0000_0000_0000_0000 - 64'h4);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBADB_AD00;
    chk("mid_rst_req", {63'h0, mem_req}, 64'h0);
    chk("mid_rst_pc", pc, 64'h0);
    chk("mid_rst_instr", {32'h0, instruction}, 64'h0);
    chk("mid_rst_valid", {63'h0, instr_valid}, 64'h0);
    tick();
    mem_ack = 1'b0;
    chk("mid_stray_valid", {63'h0, instr_valid}, 64'h0);
    chk("mid_resume_req", {63'h0, mem_req}, 64'h1);
    chk("mid_resume_addr", mem_addr, 64'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("mid_refetch_instr", {32'h0, instruction}, {32'h0, 32'h1234_5678});
    chk("mid_refetch_valid", {63'h0, instr_valid}, 64'h1);

    // Misaligned register target
    instr_advance = 1'b1; pc_sel = 2'b10; branch_reg = 64'h1002;
    tick();
    instr_advance = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("align_fault", {63'h0, fault}, 64'h1);
    chk("align_req", {63'h0, mem_req}, 64'h0);
    chk("align_valid", {63'h0, instr_valid}, 64'h0);
    chk("align_pc", pc, 64'h0);
    mem_ack = 1'b1; instr_advance = 1'b1; pc_sel = 2'b00;
    tick(); tick();
    mem_ack = 1'b0; instr_advance = 1'b0;
    chk("align_sticky", {63'h0, fault}, 64'h1);
    chk("align_sticky_req", {63'h0, mem_req}, 64'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("align_rst_fault", {63'h0, fault}, 64'h0);
`else
    chk("align_addr", mem_addr, 64'h1000);
    chk("align_fault", {63'h0, fault}, 64'h0);
    chk("align_req", {63'h0, mem_req}, 64'h1);
    chk("align_valid", {63'h0, instr_valid}, 64'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/legv8_fetch_unit.md
# legv8_fetch_unit

Instruction-supply end of the LEGv8 control path: owns the program counter, fetches 32-bit instruction words from instruction memory over a req/ack handshake, and presents one instruction at a time to the control unit's `instruction` input. When the control unit signals that the current instruction is finished, the unit computes the next PC from the control unit's PC-select fields (sequential, PC-relative branch, or register branch) and fetches again.

## Interface
- PC_RESET, 64'h0000_0000_0000_0000, PC value loaded on reset
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instruction  out  32  current instruction word to control unit
- instr_valid  out  1  `instruction` and `pc` hold a fetched, unconsumed instruction
- pc  out  64  byte address of `instruction`
- instr_advance  in  1  control unit finished current instruction; sampled only while instr_valid=1
- pc_sel  in  2  next-PC select: 00 pc+4, 01 pc+branch_offset, 10 branch_reg, 11 hold (refetch pc)
- branch_offset  in  64  sign-extended byte offset (already shifted ×4)
- branch_reg  in  64  register target for BR
- mem_addr  out  64  fetch address, equals pc
- mem_req  out  1  fetch request
- mem_rdata  in  32  fetched word, valid when mem_ack=1
- mem_ack  in  1  memory completes request this cycle
- fault  out  1  misaligned-target fault (see Configuration)

## Operation
- States: IDLE, REQ, VALID, FAULT.
- IDLE: entered by reset; unconditional transition to REQ next cycle.
- REQ: mem_req=1, mem_addr=pc stable. On mem_ack=1: capture mem_rdata into instruction, go VALID. Without ack, remain (no timeout).
- VALID: instr_valid=1, mem_req=0. On instr_advance=1: pc <= next_pc, go REQ. Otherwise hold; instruction and pc stable.
- next_pc: 00 → pc+4; 01 → pc+branch_offset; 10 → branch_reg; 11 → pc. All 64-bit modulo 2^64 (wrap, no overflow flag).
- pc_sel, branch_offset, branch_reg sampled only in the cycle instr_advance=1 in VALID.
- instr_advance outside VALID ignored. mem_ack outside REQ ignored; mem_rdata ignored when mem_ack=0.
- FAULT: see Configuration; exited only by reset.

## Timing
- Reset values: pc=PC_RESET, instruction=32'h0, instr_valid=0, mem_req=0, mem_addr=PC_RESET, fault=0, state IDLE.
- First mem_req: second rising edge after reset deasserts (IDLE for one cycle).
- mem_ack in same cycle as first mem_req permitted: instr_valid=1 on next cycle (minimum fetch latency 1 cycle from req to valid).
- instr_advance at cycle N in VALID: cycle N+1 instr_valid=0, mem_req=1, pc/mem_addr=new value.
- Back-to-back throughput with zero-wait memory: one instruction per 2 cycles.
- Reset asserted in any state (including REQ awaiting ack): next edge returns to reset values; outstanding request abandoned, a late mem_ack after reset is ignored unless the unit is back in REQ.
- instruction retains last captured word while in REQ (not cleared).

## Configuration
- FETCH_ALIGN_CHECK_EN defined: on instr_advance, if next_pc[1:0]≠0, pc is not updated, state → FAULT, fault=1 next cycle and sticky; mem_req=0, instr_valid=0 until reset.
- Undefined: next_pc[1:0] forced to 2'b00; FAULT state unreachable; fault tied 0.

## Test plan
- Reset + sequential: PC_RESET=0, memory returns 32'h8B1F0000 at 0 with ack on first req → instr_valid=1, instruction=32'h8B1F0000, pc=0; advance with pc_sel=00 → mem_addr=4 next cycle.
- Wait states: ack delayed 3 cycles → mem_req held, mem_addr constant, instr_valid stays 0 until the cycle after ack.
- Branch: pc=0x40, pc_sel=01, branch_offset=-16 → next mem_addr=0x30; pc_sel=10, branch_reg=0x1000 → 0x1000; pc_sel=11 → refetch 0x40.
- Wrap: pc=64'hFFFF_FFFF_FFFF_FFFC, pc_sel=00 → pc=0.
- Reset mid-fetch: reset asserted while REQ waiting → next cycle mem_req=0, pc=PC_RESET; stray ack ignored, IDLE then REQ resume.
- Alignment: branch_reg=0x1002, pc_sel=10 → with FETCH_ALIGN_CHECK_EN fault=1, mem_req=0, pc unchanged; without, mem_addr=0x1000, fault=0.
